// File: rtl/mm_pkg.sv
// Shared definitions for the parallel matrix multiplier: default sizes,
// control FSM states and the flat-array element index helper.
package mm_pkg;

    localparam int unsigned MAX_SIZE = 10;
    localparam int unsigned DW       = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mm_state_e;

    // Element (i,j) of a row-major flat matrix with the given row stride.
    function automatic int unsigned idx(input int unsigned i,
                                        input int unsigned j,
                                        input int unsigned stride);
        return i * stride + j;
    endfunction

endpackage

// File: rtl/mm_mac_cell.sv
// Multiply-accumulate cell owning one C[i][j]; product and sum wrap modulo 2^DW.
module mm_mac_cell #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] acc
);

    logic [DW-1:0] acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + a * b;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/matrix_mult_parallel.sv
// C = A x B on a MAX_SIZE x MAX_SIZE array of MAC cells, one k term per cycle,
// behind a start/busy/done handshake.
module matrix_mult_parallel #(
    parameter int unsigned MAX_SIZE = mm_pkg::MAX_SIZE,
    parameter int unsigned DW       = mm_pkg::DW
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [31:0]                    matrix_size,
    input  logic [MAX_SIZE*MAX_SIZE*DW-1:0] a_flat,
    input  logic [MAX_SIZE*MAX_SIZE*DW-1:0] b_flat,
    output logic [MAX_SIZE*MAX_SIZE*DW-1:0] c_flat,
    output logic                           busy,
    output logic                           done
);

    import mm_pkg::*;

    localparam int unsigned CELLS = MAX_SIZE * MAX_SIZE;
    localparam int unsigned NW    = $clog2(MAX_SIZE + 1);

    mm_state_e            state_q, state_d;
    logic [NW-1:0]        k_q, k_d;
    logic [NW-1:0]        n_q, n_d;
    logic [NW-1:0]        n_req;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [CELLS*DW-1:0]  a_q, b_q;
    logic [CELLS*DW-1:0]  c_q, c_d;
    logic                 accept;
    logic                 run_en;
    logic [DW-1:0]        a_col [MAX_SIZE];
    logic [DW-1:0]        b_row [MAX_SIZE];
    logic [DW-1:0]        acc   [CELLS];

    always_comb begin
        n_req = (matrix_size > 32'(MAX_SIZE)) ? NW'(MAX_SIZE) : NW'(matrix_size);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        c_d     = c_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    n_d     = n_req;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = (n_req == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                k_d = k_q + NW'(1);
                if ((k_q + NW'(1)) == n_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Cells outside the active n x n window hold junk from unused operands.
                for (int unsigned i = 0; i < MAX_SIZE; i++) begin
                    for (int unsigned j = 0; j < MAX_SIZE; j++) begin
                        c_d[idx(i, j, MAX_SIZE)*DW +: DW] =
                            (i < 32'(n_q) && j < 32'(n_q)) ? acc[idx(i, j, MAX_SIZE)] : '0;
                    end
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            n_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            c_q     <= c_d;
            if (accept) begin
                a_q <= a_flat;
                b_q <= b_flat;
            end
        end
    end

    // Column k of A feeds every row; row k of B feeds every column.
    always_comb begin
        for (int unsigned i = 0; i < MAX_SIZE; i++) begin
            a_col[i] = a_q[idx(i, 32'(k_q), MAX_SIZE)*DW +: DW];
            b_row[i] = b_q[idx(32'(k_q), i, MAX_SIZE)*DW +: DW];
        end
    end

    assign run_en = (state_q == RUN);

    for (genvar gi = 0; gi < MAX_SIZE; gi++) begin : g_row
        for (genvar gj = 0; gj < MAX_SIZE; gj++) begin : g_col
            mm_mac_cell #(
                .DW(DW)
            ) u_cell (
                .clk (clk),
                .rst (rst),
                .clr (accept),
                .en  (run_en),
                .a   (a_col[gi]),
                .b   (b_row[gj]),
                .acc (acc[gi*MAX_SIZE+gj])
            );
        end
    end

    assign c_flat = c_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_matrix_mult_parallel.sv
// Directed checks of matrix_mult_parallel: results, latency, clamping, wrap,
// ignored start, mid-run reset and the size-0 case.
module tb_matrix_mult_parallel;

    localparam int unsigned N  = 10;
    localparam int unsigned W  = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [31:0]         matrix_size = '0;
    logic [N*N*W-1:0]    a_flat = '0;
    logic [N*N*W-1:0]    b_flat = '0;
    logic [N*N*W-1:0]    c_flat;
    logic                busy;
    logic                done;

    logic [31:0] A [N][N];
    logic [31:0] B [N][N];
    logic [31:0] E [N][N];

    int n_checks = 0;
    int n_pass   = 0;

    matrix_mult_parallel #(
        .MAX_SIZE(N),
        .DW      (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .matrix_size(matrix_size),
        .a_flat     (a_flat),
        .b_flat     (b_flat),
        .c_flat     (c_flat),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                A[i][j] = '0; B[i][j] = '0; E[i][j] = '0;
            end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_flat[(i*N+j)*W +: W] = A[i][j];
                b_flat[(i*N+j)*W +: W] = B[i][j];
            end
    endtask

    task automatic check_c(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("%s.c[%0d][%0d]", tag, i, j), c_flat[(i*N+j)*W +: W], E[i][j]);
    endtask

    task automatic load_3x3();
        int tbl_c [3][3] = '{'{30, 24, 18}, '{84, 69, 54}, '{138, 114, 90}};
        clear_all();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                A[i][j] = 32'(i*3 + j + 1);
                B[i][j] = 32'(9 - (i*3 + j));
                E[i][j] = 32'(tbl_c[i][j]);
            end
        pack();
    endtask

    // Accept start at edge E0, then count edges until done rises.
    task automatic run(input int size, input int exp_lat, input bit disturb, input string tag);
        int cyc;
        bit seen;
        @(negedge clk);
        matrix_size = 32'(size);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, ".busy_run"}, 32'(busy), 32'd1);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1 cyc++;
            if (done) seen = 1'b1;
            else if (disturb && cyc == 1) begin
                a_flat = ~a_flat;
                matrix_size = 32'd1;
                start = 1'b1;
            end else if (disturb && cyc == 2) start = 1'b0;
        end
        check({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        check_c(tag);
        @(posedge clk);
        #1 check({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int pulses;

        clear_all();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check_c("reset");

        load_3x3();
        run(3, 4, 1'b0, "mm3x3");

        clear_all();
        A[0][0] = 32'd7; B[0][0] = 32'd6; E[0][0] = 32'd42;
        A[0][1] = 32'd5; B[1][0] = 32'd5;
        pack();
        run(1, 2, 1'b0, "mm1x1");

        clear_all();
        for (int i = 0; i < N; i++) begin
            A[i][i] = 32'd1;
            for (int j = 0; j < N; j++) begin
                B[i][j] = 32'(i*10 + j);
                E[i][j] = 32'(i*10 + j);
            end
        end
        pack();
        run(10, 11, 1'b0, "ident10");
        run(15, 11, 1'b0, "ident15");

        clear_all();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                A[i][j] = 32'hFFFF_FFFF;
                B[i][j] = 32'd2;
            end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) E[i][j] = 32'hFFFF_FFFC;
        pack();
        run(2, 3, 1'b0, "wrap2");

        load_3x3();
        run(3, 4, 1'b1, "ignore");

        load_3x3();
        @(negedge clk);
        matrix_size = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst.c00", c_flat[0 +: W], 32'd0);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        @(negedge clk) rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1 if (done) pulses++;
        end
        check("midrst.no_done", 32'(pulses), 32'd0);
        check("midrst.idle_busy", 32'(busy), 32'd0);

        load_3x3();
        run(3, 4, 1'b0, "pre0");
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) E[i][j] = '0;
        run(0, 1, 1'b0, "size0");
        load_3x3();
        run(3, 4, 1'b0, "post0");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
